palette_lut: RTL and testbench
==============================

# palette_lut

Programmable colour-lookup and video output stage for the EG2000 core, generalised in palette depth, channel width and output mode. It sits between the video generator (pixel, 4-bit colour index, syncs) and the video mixer. It replaces the fixed 16-entry palette with a writable RAM, loaded with the Colour Genie defaults after reset. Outputs are pipelined with sync-aligned delays, and the block adds greyscale, green and amber monochrome modes.

## Interface
- `COLORS`, default 16: palette entries; power of two, 16..256. `IW = log2(COLORS)`.
- `CW`, default 6: bits per RGB channel, 4..8.
- `clock  in  1`: system clock (35.468 MHz).
- `power  in  1`: synchronous, active-low reset. Low holds the block in reset; sampled on the `clock` rising edge.
- `ce_pix  in  1`: pixel enable from the video generator.
- `pixel  in  1`: active-video flag. 0 forces black output.
- `color  in  IW`: palette index.
- `hsync`, `vsync`  in  1 each: input syncs, active high.
- `mode  in  2`: 0 = colour, 1 = grey, 2 = green mono, 3 = amber mono. Sampled at stage 2 each cycle.
- `wr_req  in  1`: host palette write request (level).
- `wr_idx  in  IW`: entry to write.
- `wr_rgb  in  3*CW`: new value as {R,G,B}.
- `wr_ack  out  1`: one-cycle pulse when a write is accepted.
- `ready  out  1`: 1 once the default load has completed.
- `r_out`, `g_out`, `b_out`  out  CW each: output colour.
- `hs_out`, `vs_out`, `ce_out`  out  1 each: delayed `hsync`, `vsync` and `ce_pix`.

## Operation
- The FSM has three states: RESET, INIT and RUN.
  - RESET is entered while `power`=0. The load counter is cleared and every output register goes to 0, including `ready` and `wr_ack`.
  - INIT is entered on the first cycle with `power`=1. It writes one default entry per clock, index 0 up to COLORS-1, which takes COLORS cycles. It then moves to RUN and sets `ready`=1.
  - If `power` drops during INIT, the block returns to RESET and INIT restarts from index 0.
- Default table, entries 0..15 as R,G,B for CW=6:
  - 0: 16,16,16
  - 1: 24,56,56
  - 2: 48,8,16
  - 3: 56,56,56
  - 4: 56,56,8
  - 5: 40,56,16
  - 6: 56,24,8
  - 7: 48,56,8
  - 8: 8,16,56
  - 9: 40,48,56
  - 10: 48,16,56
  - 11: 32,24,56
  - 12: 32,32,32
  - 13: 8,48,32
  - 14: 32,8,56
  - 15: 56,56,56
- Default table scaling and unused entries:
  - For CW>6, each value is shifted left by CW-6 with zero fill.
  - For CW<6, each value is shifted right by 6-CW.
  - Entries 16 and above default to 0.
- Host writes:
  - Accepted only in RUN, when `wr_req`=1 and `wr_ack` was 0 in the previous cycle.
  - The entry is written that edge and `wr_ack` pulses for one cycle. A held `wr_req` therefore produces at most one write every 2 cycles.
  - Requests during RESET or INIT are held off: no ack is given, and the request is serviced on the first RUN cycle.
- Stage 1 (pixel path):
  - Registers the RAM read of `color` (read-during-write returns the old value).
  - Registers `pixel`, `hsync`, `vsync` and `ce_pix` alongside it.
- Stage 2 (transform, then registered outputs):
  - The luma is `Y = (R + 2G + B) >> 2`, computed at CW+2 bits with no overflow, then truncated to CW bits.
  - Mode 0 outputs R,G,B unchanged.
  - Mode 1 outputs Y,Y,Y.
  - Mode 2 outputs 0,Y,0.
  - Mode 3 outputs Y, (Y>>1)+(Y>>2), 0.
  - If the stage-1 `pixel` is 0, RGB is 0 regardless of mode.
- The pixel pipeline runs in every state. During RESET and INIT, RGB outputs are 0 but syncs and `ce_out` still propagate.

## Timing
- Latency is 2 clocks from `color`/`pixel`/`hsync`/`vsync`/`ce_pix` to the corresponding outputs. All outputs of one pixel appear on the same cycle.
- The pipeline advances every clock and is not gated by `ce_pix`. `ce_out` marks valid pixels.
- A write accepted at edge N is visible on the RGB outputs for a lookup of that index presented at edge N+1 or later. A lookup at edge N sees the old value.
- `ready` rises on the edge that completes the write to index COLORS-1. This is COLORS clocks after the first cycle with `power` high.
- A `mode` change affects outputs 1 clock later.

## Test plan
- **Reset and default load:** hold `power`=0 for 4 cycles, then release. All outputs are 0 during reset, and `ready` goes to 1 after exactly 16 clocks (COLORS=16). Then look up `color`=2 with `pixel`=1: 2 clocks later RGB = 48,8,16.
- **Sync alignment:** drive an `hsync` pulse with `pixel`=0 and `color`=15. `hs_out` appears 2 clocks later and RGB is 0,0,0.
- **Write handshake:** in RUN, hold `wr_req`=1 with `wr_idx`=5 and `wr_rgb`=63,0,0. `wr_ack` pulses on cycles 1, 3, 5 and so on. A lookup of 5 issued the cycle after the first ack returns 63,0,0. A same-cycle lookup returns 40,56,16.
- **Modes:** use entry 9 = 40,48,56 and set `mode`=1. Output is 48,48,48. With `mode`=2 the output is 0,48,0; with `mode`=3 it is 48,36,0.
- **Reset during INIT:** drop `power` for 1 cycle at INIT index 7. `ready` stays 0, and `ready` rises 16 clocks after `power` returns high. A `wr_req` held throughout is acknowledged on the first cycle after `ready` goes high.
- **Wide variant:** with COLORS=256 and CW=8, `ready` is set after 256 clocks. Entry 3 reads 224,224,224 and entry 200 reads 0,0,0.

Source files
------------

// File: rtl/palette_lut.sv
// Writable colour palette with a power-up default load, a two-stage pixel
// pipeline and colour / grey / green / amber output modes.
module palette_lut #(
  parameter  int COLORS = 16,
  parameter  int CW     = 6,
  localparam int IW     = $clog2(COLORS)
) (
  input  logic            clock,
  input  logic            power,
  input  logic            ce_pix,
  input  logic            pixel,
  input  logic [IW-1:0]   color,
  input  logic            hsync,
  input  logic            vsync,
  input  logic [1:0]      mode,
  input  logic            wr_req,
  input  logic [IW-1:0]   wr_idx,
  input  logic [3*CW-1:0] wr_rgb,
  output logic            wr_ack,
  output logic            ready,
  output logic [CW-1:0]   r_out,
  output logic [CW-1:0]   g_out,
  output logic [CW-1:0]   b_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ce_out
);

  localparam int SHL = (CW > 6) ? CW - 6 : 0;
  localparam int SHR = (CW < 6) ? 6 - CW : 0;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_e;

  state_e          state_q;
  logic [IW-1:0]   cnt_q;
  logic            ready_q, wr_ack_q;
  logic [3*CW-1:0] mem [COLORS];
  logic [3*CW-1:0] rd_q;
  logic            pix1_q, hs1_q, vs1_q, ce1_q, run1_q;
  logic [CW-1:0]   r_q, g_q, b_q, r_d, g_d, b_d;
  logic            hs_q, vs_q, ce_q;
  logic            wr_accept, mem_we;
  logic [IW-1:0]   mem_addr;
  logic [3*CW-1:0] mem_data;
  logic [CW-1:0]   r1, g1, b1, lum;
  logic [CW+1:0]   lum_sum;

  function automatic logic [CW-1:0] scale(input logic [5:0] v);
    return CW'(({2'b00, v} << SHL) >> SHR);
  endfunction

  // Colour Genie defaults, stored as 6-bit {R,G,B} and rescaled to CW bits.
  function automatic logic [3*CW-1:0] default_rgb(input logic [IW-1:0] idx);
    logic [17:0] base;
    case (int'(idx))
      0:       base = {6'd16, 6'd16, 6'd16};
      1:       base = {6'd24, 6'd56, 6'd56};
      2:       base = {6'd48, 6'd8,  6'd16};
      3:       base = {6'd56, 6'd56, 6'd56};
      4:       base = {6'd56, 6'd56, 6'd8 };
      5:       base = {6'd40, 6'd56, 6'd16};
      6:       base = {6'd56, 6'd24, 6'd8 };
      7:       base = {6'd48, 6'd56, 6'd8 };
      8:       base = {6'd8,  6'd16, 6'd56};
      9:       base = {6'd40, 6'd48, 6'd56};
      10:      base = {6'd48, 6'd16, 6'd56};
      11:      base = {6'd32, 6'd24, 6'd56};
      12:      base = {6'd32, 6'd32, 6'd32};
      13:      base = {6'd8,  6'd48, 6'd32};
      14:      base = {6'd32, 6'd8,  6'd56};
      15:      base = {6'd56, 6'd56, 6'd56};
      default: base = '0;
    endcase
    return {scale(base[17:12]), scale(base[11:6]), scale(base[5:0])};
  endfunction

  // A held request is taken only when the previous cycle did not ack.
  assign wr_accept = power && (state_q == ST_RUN) && wr_req && !wr_ack_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = cnt_q;
    mem_data = default_rgb(cnt_q);
    if (power && (state_q != ST_RUN)) begin
      mem_we = 1'b1;
    end else if (wr_accept) begin
      mem_we   = 1'b1;
      mem_addr = wr_idx;
      mem_data = wr_rgb;
    end
  end

  // RESET with power high already performs the index-0 write of the load.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!power) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET, ST_INIT: begin
          cnt_q    <= cnt_q + 1'b1;
          wr_ack_q <= 1'b0;
          if (cnt_q == IW'(COLORS - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_INIT;
          end
        end
        ST_RUN:  wr_ack_q <= wr_accept;
        default: state_q  <= ST_RESET;
      endcase
    end
  end

  // NOTE: the palette RAM is deliberately not reset; the INIT load rewrites every entry.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    rd_q <= mem[color];
  end

  assign r1      = rd_q[3*CW-1:2*CW];
  assign g1      = rd_q[2*CW-1:CW];
  assign b1      = rd_q[CW-1:0];
  assign lum_sum = {2'b00, r1} + {1'b0, g1, 1'b0} + {2'b00, b1};
  assign lum     = CW'(lum_sum >> 2);

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (pix1_q && run1_q) begin
      case (mode)
        2'd0: begin r_d = r1;  g_d = g1;  b_d = b1;  end
        2'd1: begin r_d = lum; g_d = lum; b_d = lum; end
        2'd2: g_d = lum;
        default: begin r_d = lum; g_d = (lum >> 1) + (lum >> 2); end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!power) begin
      pix1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; ce1_q <= 1'b0; run1_q <= 1'b0;
      r_q    <= '0;   g_q   <= '0;   b_q   <= '0;
      hs_q   <= 1'b0; vs_q  <= 1'b0; ce_q  <= 1'b0;
    end else begin
      pix1_q <= pixel;  hs1_q <= hsync; vs1_q <= vsync; ce1_q <= ce_pix;
      run1_q <= (state_q == ST_RUN);
      r_q    <= r_d;    g_q   <= g_d;   b_q   <= b_d;
      hs_q   <= hs1_q;  vs_q  <= vs1_q; ce_q  <= ce1_q;
    end
  end

  assign wr_ack = wr_ack_q;
  assign ready  = ready_q;
  assign r_out  = r_q;
  assign g_out  = g_q;
  assign b_out  = b_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign ce_out = ce_q;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: default load, lookup/mode table, write
// handshake, reset during the load and a 256-entry / 8-bit variant.
module tb_palette_lut;

  logic        clock;
  logic        power, ce_pix, pixel, hsync, vsync, wr_req, wr_ack, ready;
  logic [3:0]  color, wr_idx;
  logic [1:0]  mode;
  logic [17:0] wr_rgb;
  logic [5:0]  r_out, g_out, b_out;
  logic        hs_out, vs_out, ce_out;

  logic        w_power, w_pixel, w_wr_ack, w_ready, w_hs, w_vs, w_ce;
  logic [7:0]  w_color;
  logic [7:0]  w_r, w_g, w_b;

  int errors = 0;
  int checks = 0;

  palette_lut #(.COLORS(16), .CW(6)) dut (
    .clock(clock), .power(power), .ce_pix(ce_pix), .pixel(pixel), .color(color),
    .hsync(hsync), .vsync(vsync), .mode(mode), .wr_req(wr_req), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .wr_ack(wr_ack), .ready(ready), .r_out(r_out), .g_out(g_out),
    .b_out(b_out), .hs_out(hs_out), .vs_out(vs_out), .ce_out(ce_out)
  );

  palette_lut #(.COLORS(256), .CW(8)) dut_wide (
    .clock(clock), .power(w_power), .ce_pix(1'b1), .pixel(w_pixel), .color(w_color),
    .hsync(1'b0), .vsync(1'b0), .mode(2'd0), .wr_req(1'b0), .wr_idx(8'd0),
    .wr_rgb(24'd0), .wr_ack(w_wr_ack), .ready(w_ready), .r_out(w_r), .g_out(w_g),
    .b_out(w_b), .hs_out(w_hs), .vs_out(w_vs), .ce_out(w_ce)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rgb6(input int r, input int g, input int b);
    return {14'b0, 6'(r), 6'(g), 6'(b)};
  endfunction

  function automatic logic [31:0] act6();
    return {14'b0, r_out, g_out, b_out};
  endfunction

  task automatic lookup(input string name, input logic [3:0] c, input logic [1:0] m,
                        input logic [31:0] exp);
    color = c; mode = m; pixel = 1'b1;
    step();
    step();
    check(name, act6(), exp);
  endtask

  typedef struct {
    logic [3:0] color;
    logic       pixel;
    logic [1:0] mode;
    logic       hs, vs, ce;
    int         er, eg, eb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    int ack_seen;

    vecs[0] = '{4'd2,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 48, 8,  16};
    vecs[1] = '{4'd0,  1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 16, 16, 16};
    vecs[2] = '{4'd15, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 56, 56, 56};
    vecs[3] = '{4'd9,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 48, 48, 48};
    vecs[4] = '{4'd9,  1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 0,  48, 0 };
    vecs[5] = '{4'd9,  1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 48, 36, 0 };
    vecs[6] = '{4'd13, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 34, 34, 34};
    vecs[7] = '{4'd6,  1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 28, 21, 0 };
    vecs[8] = '{4'd15, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 0,  0,  0 };
    vecs[9] = '{4'd11, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32, 24, 56};

    power = 1'b0; ce_pix = 1'b1; pixel = 1'b1; color = 4'd0; hsync = 1'b1; vsync = 1'b0;
    mode = 2'd0; wr_req = 1'b0; wr_idx = 4'd0; wr_rgb = '0;
    w_power = 1'b0; w_pixel = 1'b0; w_color = 8'd0;

    // Reset: inputs active, every output must stay 0.
    for (int i = 0; i < 4; i++) step();
    check("reset_outputs",
          {r_out, g_out, b_out, hs_out, vs_out, ce_out, ready, wr_ack}, 32'd0);

    // Default load: ready after exactly 16 clocks, RGB blanked but syncs flowing.
    power = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 8) begin
        check("init_rgb_blank", act6(), 32'd0);
        check("init_syncs", {hs_out, ce_out}, 32'd3);
      end
      if (i == 15) check("ready_before_16", ready, 1'b0);
      if (ready) begin
        n = i;
        break;
      end
    end
    check("ready_latency", n, 16);
    hsync = 1'b0;

    // Lookup/mode table, each vector held for the full pipeline depth.
    for (int i = 0; i < 10; i++) begin
      color = vecs[i].color; pixel = vecs[i].pixel; mode = vecs[i].mode;
      hsync = vecs[i].hs; vsync = vecs[i].vs; ce_pix = vecs[i].ce;
      step();
      step();
      check($sformatf("vec%0d_rgb", i), act6(), rgb6(vecs[i].er, vecs[i].eg, vecs[i].eb));
      check($sformatf("vec%0d_sync", i), {hs_out, vs_out, ce_out},
            {vecs[i].hs, vecs[i].vs, vecs[i].ce});
    end
    hsync = 1'b0; vsync = 1'b0; ce_pix = 1'b1;

    // Sync alignment: a one-cycle hsync pulse emerges exactly 2 clocks later.
    pixel = 1'b0; color = 4'd15; mode = 2'd0;
    step();
    step();
    hsync = 1'b1;
    step();
    hsync = 1'b0;
    check("hs_latency_1", hs_out, 1'b0);
    step();
    check("hs_latency_2", hs_out, 1'b1);
    check("hs_rgb_black", act6(), 32'd0);
    step();
    check("hs_latency_3", hs_out, 1'b0);

    // Mode change reaches the outputs one clock later.
    lookup("mode_base", 4'd9, 2'd0, rgb6(40, 48, 56));
    mode = 2'd1;
    step();
    check("mode_change", act6(), rgb6(48, 48, 48));

    // Write handshake with a held request and a lookup of the same index.
    mode = 2'd0; color = 4'd5; pixel = 1'b1;
    wr_idx = 4'd5; wr_rgb = {6'd63, 6'd0, 6'd0}; wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("ack_pattern%0d", i), wr_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (i == 1) check("wr_same_cycle_old", act6(), rgb6(40, 56, 16));
      if (i == 2) check("wr_next_cycle_new", act6(), rgb6(63, 0, 0));
    end
    wr_req = 1'b0;
    step();
    wr_idx = 4'd12; wr_rgb = {6'd5, 6'd10, 6'd20}; wr_req = 1'b1;
    step();
    check("wr2_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    lookup("wr2_grey", 4'd12, 2'd1, rgb6(11, 11, 11));

    // Power drop at INIT index 7 restarts the load; a held request waits for RUN.
    power = 1'b0;
    step();
    power = 1'b1;
    wr_req = 1'b1; wr_idx = 4'd3; wr_rgb = {6'd1, 6'd1, 6'd1};
    ack_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (wr_ack) ack_seen++;
    end
    power = 1'b0;
    step();
    check("ready_after_drop", ready, 1'b0);
    power = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (wr_ack) ack_seen++;
      if (ready) begin
        n = i;
        break;
      end
    end
    check("reinit_latency", n, 16);
    check("no_ack_before_run", ack_seen, 0);
    step();
    check("held_req_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    step();
    lookup("reinit_written", 4'd3, 2'd0, rgb6(1, 1, 1));
    lookup("reinit_default5", 4'd5, 2'd0, rgb6(40, 56, 16));

    // Wide variant: 256 entries, 8-bit channels.
    w_power = 1'b1;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (w_ready) begin
        n = i;
        break;
      end
    end
    check("wide_ready_latency", n, 256);
    w_pixel = 1'b1;
    w_color = 8'd3;
    step();
    step();
    check("wide_entry3", {8'b0, w_r, w_g, w_b}, {8'b0, 8'd224, 8'd224, 8'd224});
    w_color = 8'd8;
    step();
    step();
    check("wide_entry8", {8'b0, w_r, w_g, w_b}, {8'b0, 8'd32, 8'd64, 8'd224});
    w_color = 8'd200;
    step();
    step();
    check("wide_entry200", {8'b0, w_r, w_g, w_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
